// File: rtl/seq_unrotator_if.sv
// Valid/ready handshake bundle for the rotate-decoder: one input channel
// carrying a rotated word with its rotate parameters, one output channel.
interface seq_unrotator_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shift;
  logic             in_left_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_shift, in_left_rot, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_left_rot, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/seq_unrotator.sv
// Iterative rotate decoder: undoes an N-position rotate by stepping a single
// 1-bit rotator N times in the opposite direction, one word in flight.
module seq_unrotator #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  seq_unrotator_if.slave      bus,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             dir_left_q, dir_left_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], w[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] w);
    return {w[0], w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    dir_left_d  = dir_left_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d     = bus.in_data;
          count_d    = bus.in_shift;
          // Decode runs against the original rotate direction.
          dir_left_d = ~bus.in_left_rot;
          state_d    = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (count_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_q;
        end else begin
          work_d  = dir_left_q ? rotl1(work_q) : rotr1(work_q);
          count_d = count_q - SHW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dir_left_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dir_left_q  <= dir_left_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Working word is pure datapath; it is always reloaded before use.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_unrotator.sv
// Randomized and directed bench for seq_unrotator against a rotate-arithmetic
// reference model.
module tb_seq_unrotator;
  localparam int W = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  seq_unrotator_if #(.WIDTH(W), .SHW(S)) bus ();

  seq_unrotator #(.WIDTH(W), .SHW(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Original word: undo a left rotate by rotating right, and vice versa.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh, input logic left);
    logic [2*W-1:0] dd;
    dd = {d, d};
    if (left) return W'(dd >> sh);
    else      return W'(dd >> (W - sh));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic process_word(input logic [W-1:0] d, input int sh, input logic left, input int hold);
    logic [W-1:0] exp;
    int cyc;
    exp = model(d, sh, left);
    chk("idle_ready", bus.in_ready, 1);
    chk("idle_busy", busy, 0);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_shift    = S'(sh);
    bus.in_left_rot = left;
    tick();
    // Garbage after accept must be ignored.
    bus.in_valid    = 1'($urandom_range(0, 1));
    bus.in_data     = W'($urandom);
    bus.in_shift    = S'($urandom);
    bus.in_left_rot = 1'($urandom);
    bus.out_ready   = (hold == 0);
    chk("accept_busy", busy, 1);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      chk("rotate_ready", bus.in_ready, 0);
      tick();
      cyc++;
    end
    chk("latency", cyc, sh + 1);
    chk("out_data", bus.out_data, exp);
    chk("done_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, exp);
      chk("hold_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hs_valid", bus.out_valid, 0);
    chk("hs_ready", bus.in_ready, 1);
    chk("hs_keep_data", bus.out_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_shift    = '0;
    bus.in_left_rot = 1'b0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);

    chk("model_r", model(8'b01110110, 3, 1'b0), 8'b10110011);
    process_word(8'b01110110, 3, 1'b0, 0);
    process_word(8'b10011101, 3, 1'b1, 0);
    process_word(8'b00110011, 2, 1'b0, 0);
    process_word(8'b00110011, 2, 1'b1, 1);
    process_word(8'hA5, 0, 1'b0, 5);
    process_word(8'hFF, 4, 1'b1, 0);
    process_word(8'b00000001, 7, 1'b1, 2);
    chk("max_shift_data", bus.out_data, 8'b00000010);

    // Reset during the third ROTATE cycle.
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'h3C;
    bus.in_shift    = 3'd5;
    bus.in_left_rot = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_data", bus.out_data, 0);
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_busy", busy, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_quiet", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      process_word(W'($urandom), $urandom_range(0, W - 1), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
